ring_shift_counter: RTL and testbench
=====================================

RING_SHIFT_COUNTER -- requirements
Module: ring_shift_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, the counter width in bits; legal range 2..32.
REQ-002 SHALL provide clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL provide en  input  1  step enable; one step per clk edge while high.
REQ-005 SHALL provide mode  input  1  counter mode; 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-006 SHALL provide dir  input  1  step direction; 0 = up (shift toward MSB), 1 = down (shift toward LSB).
REQ-007 SHALL provide load  input  1  synchronous load strobe.
REQ-008 SHALL provide load_val  input  WIDTH  value captured on load.
REQ-009 SHALL provide q  output  WIDTH  registered counter state.
REQ-010 SHALL provide idx  output  $clog2(2*WIDTH)  registered step index of q.
REQ-011 SHALL provide wrap  output  1  registered one-cycle pulse when the sequence wraps.
REQ-012 SHALL provide err  output  1  registered one-cycle pulse on illegal-state detection.

Function
REQ-013 Ring up SHALL be q <= {q[WIDTH-2:0], q[WIDTH-1]}; ring down SHALL be q <= {q[0], q[WIDTH-1:1]}.
REQ-014 Johnson up SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; Johnson down SHALL be q <= {~q[0], q[WIDTH-1:1]}.
REQ-015 Legal ring states SHALL be exactly the WIDTH one-hot values; legal Johnson states SHALL be exactly the 2*WIDTH values of the Johnson sequence starting at all-zeros.
REQ-016 The home state SHALL be 1 (bit 0 set) in ring mode and 0 in Johnson mode.
REQ-017 Per-edge priority SHALL be: reset > load > illegal-state correction > enabled step > hold.
REQ-018 On load with load_val legal for the current mode, q SHALL take load_val; if illegal, q SHALL take the home state and err SHALL pulse.
REQ-019 When not loading and q is illegal for the current mode, q SHALL take the home state on the next edge regardless of en, and err SHALL pulse.
REQ-020 A mode change SHALL take effect on the next edge; a q that is illegal under the new mode SHALL be corrected per REQ-019; a q that is legal SHALL continue stepping from its position.
REQ-021 idx in ring mode SHALL be the bit position of the set bit (0..WIDTH-1).
REQ-022 idx in Johnson mode SHALL be popcount(q) when q[WIDTH-1]=0 and 2*WIDTH-popcount(q) when q[WIDTH-1]=1.
REQ-023 q, idx, wrap and err SHALL all update on the same edge, so idx always matches q in the same cycle.
REQ-024 wrap SHALL be high for exactly the cycle in which an enabled step moved idx from last to first in the step direction: up = max->0, down = 0->max (max = WIDTH-1 ring, 2*WIDTH-1 Johnson).
REQ-025 wrap SHALL NOT assert on load, correction or reset, even when the resulting idx is 0 or max.
REQ-026 err and wrap SHALL be low in every cycle not covered by REQ-018, REQ-019 or REQ-024.
REQ-027 With en low and no load, q SHALL hold, and dir changes SHALL have no effect.
REQ-028 A step SHALL take one cycle: the step on edge n SHALL be visible on q after edge n.

Reset
REQ-029 When rst is low at a clk edge, q SHALL become the home state for the current mode, idx 0, wrap 0, err 0, overriding load and en.
REQ-030 Reset SHALL act mid-sequence with no residual state; stepping SHALL resume from home on the first edge with rst high.

Verification
REQ-031 WIDTH=4, ring, up, en=1 after reset: q=0001,0010,0100,1000,0001 on successive cycles; idx 0,1,2,3,0; wrap high only with the second 0001.
REQ-032 WIDTH=4, Johnson, down, from reset: q=0000,1000,1100,1110,1111,0111,0011,0001,0000; idx 0,7,6,5,4,3,2,1,0; wrap high with the first 1000.
REQ-033 Ring mode, load load_val=0110: q=0001 the next cycle, err high one cycle, wrap low.
REQ-034 Ring q=0100, then switch mode to Johnson with en=0: q=0000 the next cycle and err high one cycle; ring q=0001 switched to Johnson: no err, idx=1, next up step gives 0011.
REQ-035 Ring, en=1, load=1, load_val=1000, rst low on the same edge: q=0001, idx 0, no err or wrap; the next edge with rst high, load and en still high gives q=1000 and idx 3.
REQ-036 Johnson, q=1110 (idx 5), en=0 for 3 cycles while dir toggles: q holds 1110; then en=1, dir=0 gives 1100.

Source files
------------

// File: rtl/ring_shift_counter.sv
// ring_shift_counter
//   Ring (one-hot) or Johnson (twisted ring) shift counter. It can step up or
//   down, load a value, and repair any state that is illegal for the mode.
//   All outputs are registered and update on the same edge, so idx always
//   describes the q of the same cycle.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low (q -> home of current mode)
//   en       : step enable, one step per edge while high
//   mode     : 0 = ring (one-hot), 1 = Johnson
//   dir      : 0 = up (shift toward MSB), 1 = down (shift toward LSB)
//   load     : synchronous load strobe
//   load_val : value captured on load (replaced by home if illegal)
//   q        : counter state
//   idx      : step index of q within the current mode's sequence
//   wrap     : one-cycle pulse when an enabled step wraps the sequence
//   err      : one-cycle pulse when an illegal value was replaced by home
module ring_shift_counter #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         dir,
  input  logic                         load,
  input  logic [WIDTH-1:0]             load_val,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(2*WIDTH)-1:0]   idx,
  output logic                         wrap,
  output logic                         err
);

  localparam int IW = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // A ring state is legal when exactly one bit is set. A Johnson state is
  // legal when its ones form a single run anchored at the LSB (filling phase)
  // or at the MSB (draining phase); all-zeros and all-ones satisfy both.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (!m)
      return (v != '0) && ((v & (v - ONE)) == '0);
    return ((v & (v + ONE)) == '0) || ((nv & (nv + ONE)) == '0);
  endfunction

  // Position in the sequence: ring uses the set bit's position; Johnson
  // counts ones while filling and counts down from 2*WIDTH while draining.
  function automatic logic [IW-1:0] idx_of(input logic [WIDTH-1:0] v, input logic m);
    int pos;
    int pop;
    pos = 0;
    pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        pos = i;
        pop++;
      end
    end
    if (!m)
      return IW'(pos);
    if (v[WIDTH-1])
      return IW'(2*WIDTH - pop);
    return IW'(pop);
  endfunction

  logic [WIDTH-1:0] q_reg, q_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] up_q, dn_q, home;
  logic [IW-1:0]    cur_idx, max_idx;

  // Shifted candidates; Johnson mode inverts the bit fed back around the ring.
  assign up_q[0]       = mode ? ~q_reg[WIDTH-1] : q_reg[WIDTH-1];
  assign dn_q[WIDTH-1] = mode ? ~q_reg[0]       : q_reg[0];

  genvar gi;
  for (gi = 1; gi < WIDTH; gi++) begin : g_shift
    assign up_q[gi]   = q_reg[gi-1];
    assign dn_q[gi-1] = q_reg[gi];
  end

  assign home    = mode ? '0 : ONE;
  // Index of the current q under the mode in force at this edge, so a mode
  // change re-interprets a legal q before deciding whether this step wraps.
  assign cur_idx = idx_of(q_reg, mode);
  assign max_idx = mode ? IW'(2*WIDTH-1) : IW'(WIDTH-1);

  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      if (is_legal(load_val, mode)) begin
        q_next = load_val;
      end else begin
        q_next   = home;
        err_next = 1'b1;
      end
    end else if (!is_legal(q_reg, mode)) begin
      q_next   = home;
      err_next = 1'b1;
    end else if (en) begin
      if (dir) begin
        q_next    = dn_q;
        wrap_next = (cur_idx == '0);
      end else begin
        q_next    = up_q;
        wrap_next = (cur_idx == max_idx);
      end
    end
    idx_next = idx_of(q_next, mode);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg    <= home;
      idx_reg  <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      idx_reg  <= idx_next;
      wrap_reg <= wrap_next;
      err_reg  <= err_next;
    end
  end

  assign q    = q_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_ring_shift_counter.sv
// Testbench for ring_shift_counter (WIDTH=4).
// The reference model tracks the counter as a position in an explicit table
// of legal states; every negedge the DUT outputs are compared with it, and a
// set of directed scenarios compares against hand-written literal values.
module tb_ring_shift_counter;

  localparam int W  = 4;
  localparam int IW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst, en, mode, dir, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [IW-1:0] idx;
  logic          wrap, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ring_shift_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .idx(idx), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // k-th state of the sequence for a mode
  function automatic logic [W-1:0] entry(input int k, input bit m);
    logic [W-1:0] all1;
    logic [W-1:0] one;
    all1 = '1;
    one  = 4'b0001;
    if (!m) return one << k;
    if (k <= W) return W'((1 << k) - 1);
    return all1 << (k - W);
  endfunction

  function automatic int seq_len(input bit m);
    return m ? 2*W : W;
  endfunction

  // position of v in the sequence, -1 if not a member
  function automatic int find(input logic [W-1:0] v, input bit m);
    for (int k = 0; k < seq_len(m); k++)
      if (entry(k, m) === v) return k;
    return -1;
  endfunction

  logic [W-1:0] mq;
  int           midx;
  bit           mwrap, merr, mvalid = 0;

  always @(posedge clk) begin
    int k, n, nk;
    k = find(mq, mode);
    n = seq_len(mode);
    mwrap = 0;
    merr  = 0;
    if (!rst) begin
      mq = entry(0, mode);
    end else if (load) begin
      if (find(load_val, mode) >= 0) mq = load_val;
      else begin mq = entry(0, mode); merr = 1; end
    end else if (k < 0) begin
      mq = entry(0, mode);
      merr = 1;
    end else if (en) begin
      nk    = dir ? (k + n - 1) % n : (k + 1) % n;
      mwrap = dir ? (k == 0) : (k == n - 1);
      mq    = entry(nk, mode);
    end
    midx   = find(mq, mode);
    mvalid = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // compare process: every cycle once the model has seen an edge
  always @(negedge clk) begin
    cyc++;
    if (mvalid) begin
      $display("cyc %0d rst=%b ld=%b en=%b m=%b d=%b q=%b idx=%0d wrap=%b err=%b",
               cyc, rst, load, en, mode, dir, q, idx, wrap, err);
      chk("model_q",    32'(q),    32'(mq));
      chk("model_idx",  32'(idx),  32'(midx));
      chk("model_wrap", 32'(wrap), 32'(mwrap));
      chk("model_err",  32'(err),  32'(merr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string nm, input logic [W-1:0] eq, input int ei,
                         input bit ew, input bit ee);
    $display("check %s q=%b idx=%0d wrap=%b err=%b", nm, q, idx, wrap, err);
    chk({nm, "_q"},    32'(q),    32'(eq));
    chk({nm, "_idx"},  32'(idx),  32'(ei));
    chk({nm, "_wrap"}, 32'(wrap), 32'(ew));
    chk({nm, "_err"},  32'(err),  32'(ee));
  endtask

  task automatic do_reset(input bit m);
    rst = 0; mode = m; load = 0; en = 0;
    tick();
    rst = 1;
  endtask

  logic [W-1:0] r31_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int           r31_i [4] = '{1, 2, 3, 0};
  logic [W-1:0] r32_q [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0111, 4'b0011, 4'b0001, 4'b0000};
  int           r32_i [8] = '{7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    rst = 0; en = 0; mode = 0; dir = 0; load = 0; load_val = '0;

    // reset state
    tick();
    expect4("reset_ring", 4'b0001, 0, 0, 0);

    // ring up sequence with wrap on the return to 0001
    rst = 1; en = 1; dir = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect4("ring_up", r31_q[i], r31_i[i], (i == 3), 0);
    end

    // Johnson down from reset, wrap on first step
    do_reset(1);
    expect4("reset_john", 4'b0000, 0, 0, 0);
    en = 1; dir = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect4("john_down", r32_q[i], r32_i[i], (i == 0), 0);
    end

    // illegal ring load
    do_reset(0);
    load = 1; load_val = 4'b0100; tick();
    expect4("ring_load_ok", 4'b0100, 2, 0, 0);
    load_val = 4'b0110; tick();
    expect4("ring_load_bad", 4'b0001, 0, 0, 1);
    load = 0; en = 0; tick();
    expect4("ring_load_bad_after", 4'b0001, 0, 0, 0);

    // mode change: illegal q corrected, legal q re-indexed and continues
    load = 1; load_val = 4'b0100; tick();
    load = 0; mode = 1; en = 0; tick();
    expect4("mode_sw_bad", 4'b0000, 0, 0, 1);
    tick();
    expect4("mode_sw_bad_after", 4'b0000, 0, 0, 0);
    mode = 0; load = 1; load_val = 4'b0001; tick();
    load = 0; mode = 1; tick();
    expect4("mode_sw_ok", 4'b0001, 1, 0, 0);
    en = 1; dir = 0; tick();
    expect4("mode_sw_step", 4'b0011, 2, 0, 0);

    // reset overrides load and enable
    mode = 0; en = 1; load = 1; load_val = 4'b1000; rst = 0; tick();
    expect4("rst_over_load", 4'b0001, 0, 0, 0);
    rst = 1; tick();
    expect4("load_after_rst", 4'b1000, 3, 0, 0);

    // hold with dir toggling
    mode = 1; load = 1; load_val = 4'b1110; tick();
    expect4("john_load", 4'b1110, 5, 0, 0);
    load = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      dir = ~dir; tick();
      expect4("hold", 4'b1110, 5, 0, 0);
    end
    en = 1; dir = 0; tick();
    expect4("resume_up", 4'b1100, 6, 0, 0);

    // randomized phase against the model
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(99) >= 3);
      en   = ($urandom_range(99) < 70);
      dir  = $urandom_range(1);
      load = ($urandom_range(99) < 10);
      if ($urandom_range(99) < 5) mode = ~mode;
      if ($urandom_range(1))
        load_val = entry($urandom_range(seq_len(mode) - 1), mode);
      else
        load_val = W'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
